uart_config_initiator: RTL

- Master-side sequencer that opens and runs the UART configuration protocol toward a remote slave.
- Drives the TX line low for the initialization interval, then waits for the 8'hFF acknowledgment.
- Sends data-width, stop-bits and parity-mode configuration packets, each acknowledged, then the END_CONFIGURATION packet.
- Sits between the host logic and the byte-level UART transmitter/receiver inside the UART controller.

---
 rtl/uart_config_initiator.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_config_initiator.sv
// Master-side UART configuration sequencer: holds TX low for the init interval, waits for the
// slave's 8'hFF, then sends width/stop/parity packets and END_CONFIGURATION, each acknowledged.
module uart_config_initiator #(
    parameter int INIT_CYCLES    = 1_000_000,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cfg_req_i,
    input  logic [1:0] cfg_data_width_i,
    input  logic [1:0] cfg_stop_bits_i,
    input  logic [1:0] cfg_parity_i,
    output logic       tx_force_low_o,
    output logic       tx_start_o,
    output logic [7:0] tx_data_o,
    input  logic       tx_done_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o,
    output logic [1:0] err_code_o,
    output logic [5:0] cfg_o
);

    localparam int MAX_CYCLES = (INIT_CYCLES > TIMEOUT_CYCLES) ? INIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] INIT_LAST    = CW'(INIT_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX      = CW'(MAX_CYCLES);

    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_BADACK  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;
    localparam logic [7:0] ACK_BYTE    = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        INIT_LOW,
        WAIT_INIT_ACK,
        SEND_PKT,
        WAIT_TX,
        WAIT_ACK,
        ERROR,
        DONE
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [1:0]    pkt_idx, pkt_idx_next;
    logic [1:0]    req_width, req_stop, req_parity;
    logic [1:0]    err_code_next;
    logic [7:0]    tx_data_next;
    logic          latch_req;

    function automatic logic [7:0] pkt_byte(input logic [1:0] idx, input logic [1:0] width,
                                            input logic [1:0] stop, input logic [1:0] parity);
        logic [7:0] b;
        case (idx)
            2'd0:    b = {4'h0, width,  2'b01};
            2'd1:    b = {4'h0, stop,   2'b10};
            2'd2:    b = {4'h0, parity, 2'b11};
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_comb begin
        state_next    = state;
        pkt_idx_next  = pkt_idx;
        err_code_next = err_code_o;
        tx_data_next  = tx_data_o;
        latch_req     = 1'b0;

        case (state)
            IDLE: begin
                if (cfg_req_i) begin
                    if (cfg_stop_bits_i == 2'b10) begin
                        state_next    = ERROR;
                        err_code_next = ERR_ILLEGAL;
                    end else begin
                        latch_req     = 1'b1;
                        err_code_next = 2'b00;
                        state_next    = INIT_LOW;
                    end
                end
            end
            INIT_LOW: begin
                if (cnt == INIT_LAST) state_next = WAIT_INIT_ACK;
            end
            // An acknowledgment on the final counter cycle takes priority over the timeout.
            WAIT_INIT_ACK: begin
                if (rx_valid_i) begin
                    if (rx_data_i == ACK_BYTE) begin
                        state_next   = SEND_PKT;
                        pkt_idx_next = 2'd0;
                    end else begin
                        state_next    = ERROR;
                        err_code_next = ERR_BADACK;
                    end
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next    = ERROR;
                    err_code_next = ERR_TIMEOUT;
                end
            end
            SEND_PKT: state_next = WAIT_TX;
            WAIT_TX: begin
                if (tx_done_i) state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (rx_valid_i) begin
                    if (rx_data_i != ACK_BYTE) begin
                        state_next    = ERROR;
                        err_code_next = ERR_BADACK;
                    end else if (pkt_idx == 2'd3) begin
                        state_next = DONE;
                    end else begin
                        state_next   = SEND_PKT;
                        pkt_idx_next = pkt_idx + 2'd1;
                    end
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next    = ERROR;
                    err_code_next = ERR_TIMEOUT;
                end
            end
            ERROR:   state_next = IDLE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (state_next == SEND_PKT)
            tx_data_next = pkt_byte(pkt_idx_next, req_width, req_stop, req_parity);
    end

    // Counter restarts on every state change and saturates so it can never wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            pkt_idx    <= 2'd0;
            req_width  <= 2'b00;
            req_stop   <= 2'b00;
            req_parity <= 2'b00;
            err_code_o <= 2'b00;
            tx_data_o  <= 8'h00;
            cfg_o      <= 6'b11_11_01;
        end else begin
            state      <= state_next;
            pkt_idx    <= pkt_idx_next;
            err_code_o <= err_code_next;
            tx_data_o  <= tx_data_next;
            if (state_next != state)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            if (latch_req) begin
                req_width  <= cfg_data_width_i;
                req_stop   <= cfg_stop_bits_i;
                req_parity <= cfg_parity_i;
            end
            if (state_next == DONE)
                cfg_o <= {req_width, req_stop, req_parity};
        end
    end

    assign tx_force_low_o = (state == INIT_LOW);
    assign tx_start_o     = (state == SEND_PKT);
    assign busy_o         = (state == INIT_LOW) || (state == WAIT_INIT_ACK) || (state == SEND_PKT)
                         || (state == WAIT_TX) || (state == WAIT_ACK);
    assign done_o         = (state == DONE);
    assign error_o        = (state == ERROR);

endmodule
